game_timer_bcd: RTL and testbench
=================================

# game_timer_bcd

Elapsed-time stopwatch for a maze run, kept directly in BCD as MM:SS (00:00–99:59). Sits immediately upstream of the four-digit seven-segment scan driver and supplies its four digit inputs. Game control logic starts, pauses, finishes and clears the timer with single-cycle pulses. The frozen time remains on the display after the goal is reached.

## Interface
- `CLK_HZ`, default 100_000_000: `clk` cycles per elapsed second. The bench uses 10.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begin counting from IDLE, or resume from PAUSED.
- `pause`  in  1  pulse; RUNNING→PAUSED, or PAUSED→RUNNING.
- `finish`  in  1  pulse; freeze the time and enter DONE.
- `clear`  in  1  pulse; return to IDLE at 00:00.
- `digit0`  out  4  seconds ones, BCD.
- `digit1`  out  4  minutes tens, BCD.
- `digit2`  out  4  minutes ones, BCD.
- `digit3`  out  4  seconds tens, BCD, range 0–5.
- `running`  out  1  high in RUNNING.
- `done`  out  1  high in DONE.
- `sec_tick`  out  1  one-cycle pulse on each seconds increment.

Digit ordering matches the scan driver's anode order. Left to right, the display reads digit1 digit2 digit3 digit0 = M M S S.

## Operation
- States: IDLE, RUNNING, PAUSED, DONE.
- Transitions:
  - IDLE + `start` → RUNNING.
  - RUNNING + `pause` → PAUSED.
  - PAUSED + `pause` or `start` → RUNNING.
  - RUNNING/PAUSED + `finish` → DONE.
  - Any state + `clear` → IDLE.
  - DONE ignores `start`, `pause` and `finish`.
- Input priority in one cycle: `clear` > `finish` > `pause` > `start`. Lower-priority pulses in that cycle are dropped.
- Prescaler behaviour:
  - Counts 0..CLK_HZ-1, advancing only in RUNNING.
  - Holds its value in PAUSED, so a resumed second is not restarted.
  - Zeroed in IDLE and on `clear`.
- Increment rule: when RUNNING and prescaler == CLK_HZ-1, the prescaler wraps to 0, the time increments by one second and `sec_tick` pulses.
- BCD chain:
  - digit0 wraps 9→0 and carries to digit3.
  - digit3 wraps 5→0 and carries to digit2.
  - digit2 wraps 9→0 and carries to digit1.
  - digit1 never wraps.
- Saturation: an increment that reaches 99:59 moves the FSM to DONE in that same edge, so the time never rolls over.
- Simultaneous `finish` and increment edge: the increment is dropped, the time freezes at its pre-tick value and `sec_tick` stays low.
- `clear` zeros all digits and the prescaler, and drops any coincident tick.
- Digits are never outside BCD range.

## Timing
- Reset (async assert) values:
  - All digits = 0.
  - `running` = 0, `done` = 0, `sec_tick` = 0.
  - State = IDLE, prescaler = 0.
- All outputs are registered; there is no combinational input→output path.
- `start` sampled at edge E: `running` = 1 after E. The first increment, to 00:01, lands at edge E+CLK_HZ.
- `pause` at edge P: no increment at P or while paused. The remaining count resumes after the resume edge.
- `finish`/`clear`: state and output effects are visible after the sampling edge (latency 1).
- `sec_tick` is high for exactly the cycle following the incrementing edge. It coincides with the updated digits.
- Reset asserted mid-count: immediate return to 00:00 IDLE. Operation resumes only on a fresh `start` after deassertion.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, RUNNING=1, PAUSED=2, DONE=3);
  - BCD limits SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_MAX=9.
- Sub-module `bcd_digit`, instantiated four times:
  - Inputs: `clk`, `rst`, `clr`, `inc`, parameter MAX.
  - Outputs: 4-bit `value`, and `carry` (= `inc` && `value`==MAX).
- Top level holds the FSM, prescaler, saturation detect and `sec_tick` register.

## Test plan
- Start and count (CLK_HZ=10): reset, pulse `start`, run 125 cycles → digits read 00:12 (digit3=1, digit0=2), with 12 `sec_tick` pulses 10 cycles apart.
- Carry chain: count to 00:59, then 10 more cycles → 01:00 (digit2=1, digit3=0, digit0=0).
- Pause mid-second: start, `pause` at cycle 5, hold 30 cycles, `pause` again → first increment lands 5 cycles after resume, and no tick occurs while paused.
- Finish vs. tick collision: `finish` on the incrementing edge at 00:03 → digits freeze at 00:03, `done`=1, no `sec_tick`; a later `start` is ignored.
- Saturation: preload via long run to 99:58, run 10 cycles → 99:59, `done`=1, `running`=0; after 50 more cycles the time is still 99:59.
- Clear and reset mid-run:
  - `clear` at 00:07 → 00:00 IDLE next cycle.
  - Async `rst` pulse between edges while RUNNING → outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_timer_bcd_pkg.sv
// Shared constants for the MM:SS BCD maze-run timer: FSM encoding, per-digit
// BCD limits and the "one second before saturation" detector.
package game_timer_bcd_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX      = 4'd9;

  // True at 99:58, where the next increment lands on the final displayable time.
  function automatic logic at_pre_sat(input logic [3:0] m_tens, input logic [3:0] m_ones,
                                      input logic [3:0] s_tens, input logic [3:0] s_ones);
    return (m_tens == MIN_MAX) && (m_ones == MIN_MAX) &&
           (s_tens == SEC_TENS_MAX) && (s_ones == SEC_ONES_MAX - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: wraps MAX->0 on inc and reports a carry into the
// next more significant digit in the same cycle.
module bcd_digit
  import game_timer_bcd_pkg::*;
#(
  parameter logic [3:0] MAX = SEC_ONES_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] value_q, value_d;

  // ">=" keeps the digit inside BCD range even from a corrupted value.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = (value_q >= MAX) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/game_timer_bcd.sv
// Maze-run stopwatch: FSM, one-second prescaler and a BCD MM:SS chain that
// freezes on finish and saturates at 99:59 by entering DONE.
module game_timer_bcd
  import game_timer_bcd_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       finish,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       done,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  // Chain order, least significant first: sec ones, sec tens, min ones, min tens.
  localparam logic [3:0] DIGIT_MAX [4] = '{SEC_ONES_MAX, SEC_TENS_MAX, MIN_MAX, MIN_MAX};

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q;

  logic          presc_at_max;
  logic          tick_en;
  logic          pre_sat;
  logic [3:0]    chain_val [4];
  logic [4:0]    chain_inc;

  assign presc_at_max = (presc_q == PRESC_MAX);

  // Any higher-priority control pulse on the wrap edge swallows the increment.
  assign tick_en = (state_q == ST_RUNNING) && presc_at_max && !clear && !finish && !pause;

  assign chain_inc[0] = tick_en;

  for (genvar gi = 0; gi < 4; gi++) begin : g_chain
    bcd_digit #(
      .MAX(DIGIT_MAX[gi])
    ) u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clear),
      .inc  (chain_inc[gi]),
      .value(chain_val[gi]),
      .carry(chain_inc[gi+1])
    );
  end

  assign pre_sat = at_pre_sat(chain_val[3], chain_val[2], chain_val[1], chain_val[0]);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (start) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (finish) begin
            state_d = ST_DONE;
          end else begin
            // A pause landing on the wrap edge parks the prescaler at its max,
            // so the pending second completes on the first cycle after resume.
            if (!presc_at_max) begin
              presc_d = presc_q + PW'(1);
            end else if (!pause) begin
              presc_d = '0;
            end
            if (pause) begin
              state_d = ST_PAUSED;
            end else if (tick_en && (pre_sat || chain_inc[4])) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSED: begin
          if (finish) begin
            state_d = ST_DONE;
          end else if (pause || start) begin
            state_d = ST_RUNNING;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_tick_q <= tick_en;
    end
  end

  assign digit0   = chain_val[0];
  assign digit3   = chain_val[1];
  assign digit2   = chain_val[2];
  assign digit1   = chain_val[3];
  assign running  = (state_q == ST_RUNNING);
  assign done     = (state_q == ST_DONE);
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_game_timer_bcd.sv
// Bench for game_timer_bcd at CLK_HZ=10: control-pulse vector table, directed
// timing sequences and random pulses against an elapsed-seconds reference model.
module tb_game_timer_bcd;

  localparam int HZ = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int NVEC = 16;

  logic       clk = 1'b0;
  logic       rst, start, pause, finish, clear;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, done, sec_tick;

  int checks = 0;
  int errors = 0;

  // Reference model: whole seconds elapsed, cycles into the current second.
  int m_state, m_secs, m_pc;
  bit m_tick;

  int n, k, ntick, last, badgap, first, seen;
  bit rs, rp, rf, rc;

  typedef struct {
    bit         s, p, f, c;
    logic [2:0] flags;   // {running, done, sec_tick}
    logic [15:0] t;      // MMSS
  } vec_t;
  vec_t tbl [NVEC];

  game_timer_bcd #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .finish(finish), .clear(clear),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .running(running), .done(done), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  wire [15:0] dut_time = {digit1, digit2, digit3, digit0};

  function automatic logic [15:0] mmss(input int secs);
    int mins = secs / 60;
    int s = secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_secs = 0; m_pc = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit f, input bit c);
    m_tick = 0;
    if (c) begin
      m_state = M_IDLE; m_secs = 0; m_pc = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          m_pc = 0;
          if (s) m_state = M_RUN;
        end
        M_RUN: begin
          if (f) m_state = M_DONE;
          else begin
            if (m_pc < HZ - 1) m_pc++;
            else if (!p) begin
              m_pc = 0; m_secs++; m_tick = 1;
              if (m_secs == 99 * 60 + 59) m_state = M_DONE;
            end
            if (p) m_state = M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (f) m_state = M_DONE;
          else if (p || s) m_state = M_RUN;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit s, input bit p, input bit f, input bit c);
    start = s; pause = p; finish = f; clear = c;
    @(posedge clk); #1;
    start = 0; pause = 0; finish = 0; clear = 0;
    model_step(s, p, f, c);
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) cycle(0, 0, 0, 0);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " time"}, 32'(dut_time), 32'(mmss(m_secs)));
    check({tag, " flags"}, 32'({running, done, sec_tick}),
          32'({m_state == M_RUN, m_state == M_DONE, m_tick}));
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 3'b000, 16'h0000};
    tbl[1]  = '{1, 0, 0, 0, 3'b100, 16'h0000};
    tbl[2]  = '{0, 1, 0, 0, 3'b000, 16'h0000};
    tbl[3]  = '{1, 0, 0, 0, 3'b100, 16'h0000};
    tbl[4]  = '{1, 0, 0, 1, 3'b000, 16'h0000};
    tbl[5]  = '{0, 1, 0, 0, 3'b000, 16'h0000};
    tbl[6]  = '{0, 0, 1, 0, 3'b000, 16'h0000};
    tbl[7]  = '{1, 0, 0, 0, 3'b100, 16'h0000};
    tbl[8]  = '{0, 1, 1, 0, 3'b010, 16'h0000};
    tbl[9]  = '{1, 0, 0, 0, 3'b010, 16'h0000};
    tbl[10] = '{0, 1, 1, 0, 3'b010, 16'h0000};
    tbl[11] = '{0, 0, 0, 1, 3'b000, 16'h0000};
    tbl[12] = '{1, 1, 0, 0, 3'b100, 16'h0000};
    tbl[13] = '{1, 1, 0, 0, 3'b000, 16'h0000};
    tbl[14] = '{0, 0, 1, 0, 3'b010, 16'h0000};
    tbl[15] = '{0, 0, 0, 1, 3'b000, 16'h0000};

    rst = 1; start = 0; pause = 0; finish = 0; clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset time", 32'(dut_time), 32'h0);
    check("reset flags", 32'({running, done, sec_tick}), 32'h0);
    rst = 0;

    // Control-pulse priority and state transitions.
    for (int i = 0; i < NVEC; i++) begin
      cycle(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].c);
      check($sformatf("vec%0d", i), 32'({running, done, sec_tick, dut_time}),
            32'({tbl[i].flags, tbl[i].t}));
    end

    // Start and count: 12 ticks exactly 10 cycles apart over 125 cycles.
    cycle(1, 0, 0, 0);
    ntick = 0; last = -1; badgap = 0;
    for (int j = 1; j <= 125; j++) begin
      idle(1);
      if (sec_tick) begin
        if (last < 0 && j != HZ) badgap++;
        if (last >= 0 && j - last != HZ) badgap++;
        last = j; ntick++;
      end
    end
    check("count ticks", 32'(ntick), 32'd12);
    check("tick spacing", 32'(badgap), 32'd0);
    check("count time", 32'(dut_time), 32'h0012);

    // Carry chain into minutes.
    n = 0;
    while (dut_time != 16'h0059 && n < 1000) begin idle(1); n++; end
    check("reach 00:59", 32'(dut_time), 32'h0059);
    idle(HZ);
    check("carry 01:00", 32'(dut_time), 32'h0100);
    cmp_model("carry");

    // Pause mid-second: remainder of the second resumes after the resume edge.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    idle(4);
    cycle(0, 1, 0, 0);
    seen = 0;
    for (int j = 0; j < 30; j++) begin idle(1); if (sec_tick || running) seen++; end
    check("paused quiet", 32'(seen), 32'd0);
    check("paused time", 32'(dut_time), 32'h0000);
    cycle(0, 1, 0, 0);
    check("resumed running", 32'(running), 32'd1);
    first = 0;
    for (int j = 1; j <= 20; j++) begin
      idle(1);
      if (sec_tick && first == 0) first = j;
    end
    check("resume tick delay", 32'(first), 32'd5);
    cmp_model("pause");

    // Finish on the incrementing edge at 00:03.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    idle(3 * HZ + HZ - 1);
    check("pre-finish time", 32'(dut_time), 32'h0003);
    cycle(0, 0, 1, 0);
    check("finish collide", 32'({running, done, sec_tick, dut_time}), 32'({3'b010, 16'h0003}));
    cycle(1, 0, 0, 0);
    idle(15);
    check("done ignores start", 32'({running, done, sec_tick, dut_time}), 32'({3'b010, 16'h0003}));
    cmp_model("finish");

    // Clear at 00:07.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    idle(7 * HZ + 3);
    check("pre-clear time", 32'(dut_time), 32'h0007);
    cycle(0, 0, 0, 1);
    check("clear", 32'({running, done, sec_tick, dut_time}), 32'({3'b000, 16'h0000}));

    // Asynchronous reset between edges while running.
    cycle(1, 0, 0, 0);
    idle(25);
    #1 rst = 1;
    #1;
    check("async rst", 32'({running, done, sec_tick, dut_time}), 32'h0);
    model_reset();
    #1 rst = 0;
    idle(5);
    check("post rst idle", 32'({running, done, sec_tick, dut_time}), 32'h0);
    cmp_model("rst");

    // Random control pulses against the model.
    for (int j = 0; j < 4000; j++) begin
      rs = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 39) == 0);
      rf = ($urandom_range(0, 299) == 0);
      rc = ($urandom_range(0, 399) == 0);
      cycle(rs, rp, rf, rc);
      cmp_model("rand");
    end

    // Saturation at 99:59.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    n = 0;
    while (dut_time != 16'h9958 && n < 70000) begin
      idle(1); cmp_model("long"); n++;
    end
    check("reach 99:58", 32'(dut_time), 32'h9958);
    idle(HZ);
    check("saturate", 32'({running, done, sec_tick, dut_time}), 32'({3'b011, 16'h9959}));
    idle(50);
    check("held 99:59", 32'({running, done, sec_tick, dut_time}), 32'({3'b010, 16'h9959}));
    cmp_model("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
